// File: rtl/cpu_trap_pkg.sv
// Shared trap definitions: interrupt-controller state encoding, mcause codes
// and the machine-mode privilege constant.
package cpu_trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRAP    = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_HANDLER = 2'd3
  } intc_state_t;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_MSI     = 4'd3;
  localparam logic [3:0] CAUSE_MTI     = 4'd7;
  localparam logic [3:0] CAUSE_MEI     = 4'd11;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

  localparam logic [1:0] PRIV_M = 2'b11;

endpackage

// File: rtl/intc_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit level; resets to 0.
module intc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// Machine-mode trap sequencer: IDLE -> TRAP -> FLUSH -> HANDLER -> IDLE.
// Define INTC_EXT_SYNC_EN to pass interrupt_ext through a two-flop synchronizer.
module interrupt_ctrl
  import cpu_trap_pkg::*;
#(
  parameter int FLUSH_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interrupt_ext,
  input  logic       interrupt_tmr,
  input  logic       interrupt_sw,
  input  logic       csr_meie,
  input  logic       csr_mtie,
  input  logic       csr_msie,
  input  logic       csr_mstatus_mie,
  input  logic       illegal_ops_ex,
  input  logic       cmd_ecall_ex,
  input  logic       cmd_mret_ex,
  input  logic       stall,
  output logic       g_interrupt,
  output logic       g_exception,
  output logic [1:0] g_interrupt_priv,
  output logic [3:0] int_cause,
  output logic       flush_req,
  output logic       in_handler,
  output logic [1:0] dbg_state
);

  logic ext_req;

`ifdef INTC_EXT_SYNC_EN
  intc_sync2 u_ext_sync (
    .clk (clk),
    .rst (rst),
    .d   (interrupt_ext),
    .q   (ext_req)
  );
`else
  assign ext_req = interrupt_ext;
`endif

  logic       mei, msi, mti, pending, exc;
  logic [3:0] irq_cause, exc_cause;

  assign mei       = ext_req & csr_meie;
  assign msi       = interrupt_sw & csr_msie;
  assign mti       = interrupt_tmr & csr_mtie;
  assign pending   = (mei | msi | mti) & csr_mstatus_mie;
  assign irq_cause = mei ? CAUSE_MEI : (msi ? CAUSE_MSI : CAUSE_MTI);
  assign exc       = illegal_ops_ex | cmd_ecall_ex;
  assign exc_cause = illegal_ops_ex ? CAUSE_ILLEGAL : CAUSE_ECALL_M;

  intc_state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  cause_q, cause_nxt;
  logic        trap_irq_q, trap_irq_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      cause_q    <= 4'd0;
      trap_irq_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cause_q    <= cause_nxt;
      trap_irq_q <= trap_irq_nxt;
    end
  end

  // Interrupts are sampled only in IDLE; an interrupt wins over a coincident
  // exception, leaving the excepting instruction to re-execute after mret.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cause_nxt    = cause_q;
    trap_irq_nxt = trap_irq_q;
    case (state)
      ST_IDLE: begin
        if (!stall) begin
          if (pending) begin
            state_nxt    = ST_TRAP;
            cause_nxt    = irq_cause;
            trap_irq_nxt = 1'b1;
          end else if (exc) begin
            state_nxt    = ST_TRAP;
            cause_nxt    = exc_cause;
            trap_irq_nxt = 1'b0;
          end
        end
      end
      ST_TRAP: begin
        state_nxt = ST_FLUSH;
        cnt_nxt   = 4'(FLUSH_CYCLES);
      end
      ST_FLUSH: begin
        if (!stall) begin
          if (cnt <= 4'd1) begin
            state_nxt = ST_HANDLER;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end
      ST_HANDLER: begin
        // A nested exception re-runs the trap/flush sequence and returns here.
        if (!stall) begin
          if (exc) begin
            state_nxt    = ST_TRAP;
            cause_nxt    = exc_cause;
            trap_irq_nxt = 1'b0;
          end else if (cmd_mret_ex) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign g_interrupt      = (state == ST_TRAP) & trap_irq_q;
  assign g_exception      = (state == ST_TRAP) & ~trap_irq_q;
  assign g_interrupt_priv = PRIV_M;
  assign int_cause        = cause_q;
  assign flush_req        = (state == ST_TRAP) | (state == ST_FLUSH);
  assign in_handler       = (state == ST_HANDLER);
  assign dbg_state        = state;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl (default FLUSH_CYCLES=3); honours INTC_EXT_SYNC_EN.
module tb_interrupt_ctrl;
  import cpu_trap_pkg::*;

`ifdef INTC_EXT_SYNC_EN
  localparam int EXT_LAT = 3;
`else
  localparam int EXT_LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       interrupt_ext = 1'b0, interrupt_tmr = 1'b0, interrupt_sw = 1'b0;
  logic       csr_meie = 1'b0, csr_mtie = 1'b0, csr_msie = 1'b0, csr_mstatus_mie = 1'b0;
  logic       illegal_ops_ex = 1'b0, cmd_ecall_ex = 1'b0, cmd_mret_ex = 1'b0, stall = 1'b0;
  logic       g_interrupt, g_exception, flush_req, in_handler;
  logic [1:0] g_interrupt_priv, dbg_state;
  logic [3:0] int_cause;

  int checks = 0;
  int errors = 0;

  interrupt_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .interrupt_ext    (interrupt_ext),
    .interrupt_tmr    (interrupt_tmr),
    .interrupt_sw     (interrupt_sw),
    .csr_meie         (csr_meie),
    .csr_mtie         (csr_mtie),
    .csr_msie         (csr_msie),
    .csr_mstatus_mie  (csr_mstatus_mie),
    .illegal_ops_ex   (illegal_ops_ex),
    .cmd_ecall_ex     (cmd_ecall_ex),
    .cmd_mret_ex      (cmd_mret_ex),
    .stall            (stall),
    .g_interrupt      (g_interrupt),
    .g_exception      (g_exception),
    .g_interrupt_priv (g_interrupt_priv),
    .int_cause        (int_cause),
    .flush_req        (flush_req),
    .in_handler       (in_handler),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Packed view of all outputs: {g_int, g_exc, flush, in_handler, cause}
  function automatic logic [7:0] outs();
    return {g_interrupt, g_exception, flush_req, in_handler, int_cause};
  endfunction

  task automatic mret_to_idle();
    cmd_mret_ex = 1'b1;
    tick();
    cmd_mret_ex = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("reset_outs", outs(), 8'h00);
    chk("reset_state", {6'd0, dbg_state}, {6'd0, ST_IDLE});
    chk("priv_reset", {6'd0, g_interrupt_priv}, 8'h03);
    rst = 1'b0;
    tick();

    // timer interrupt: pulse next cycle, cause 7, 4 flush cycles, then handler
    interrupt_tmr = 1'b1; csr_mtie = 1'b1; csr_mstatus_mie = 1'b1;
    tick();
    chk("mti_trap", outs(), 8'hA7);
    chk("priv_trap", {6'd0, g_interrupt_priv}, 8'h03);
    interrupt_tmr = 1'b0;                  // deassertion after sampling is ignored
    tick(); chk("mti_flush1", outs(), 8'h27);
    cmd_mret_ex = 1'b1;                    // mret ignored in FLUSH
    tick(); chk("mti_flush2", outs(), 8'h27);
    cmd_mret_ex = 1'b0;
    tick(); chk("mti_flush3", outs(), 8'h27);
    tick(); chk("mti_handler", outs(), 8'h17);
    mret_to_idle();
    chk("mti_idle", {6'd0, dbg_state}, {6'd0, ST_IDLE});

    // all sources at once: MEI wins, then MSI after mret
    csr_mstatus_mie = 1'b0;
    interrupt_ext = 1'b1; interrupt_sw = 1'b1; interrupt_tmr = 1'b1;
    csr_meie = 1'b1; csr_msie = 1'b1; csr_mtie = 1'b1;
    repeat (3) tick();
    chk("mie_gate", outs(), 8'h07);
    csr_mstatus_mie = 1'b1;
    tick();
    chk("all_trap_mei", outs(), 8'hAB);
    interrupt_ext = 1'b0;
    repeat (4) tick();
    chk("all_handler", outs(), 8'h1B);
    tick();
    chk("handler_blocks_irq", outs(), 8'h1B);
    mret_to_idle();
    chk("post_mret_idle", outs(), 8'h0B);
    tick();
    chk("next_trap_msi", outs(), 8'hA3);
    interrupt_sw = 1'b0; interrupt_tmr = 1'b0;
    repeat (4) tick();
    mret_to_idle();

    // illegal + ecall with no pending interrupt -> exception, cause 2
    illegal_ops_ex = 1'b1; cmd_ecall_ex = 1'b1;
    tick();
    chk("exc_trap_illegal", outs(), 8'h62);
    illegal_ops_ex = 1'b0;
    repeat (4) tick();
    chk("exc_handler", outs(), 8'h12);
    // ecall inside handler re-enters trap/flush, cause 11
    tick();
    chk("nested_ecall", outs(), 8'h6B);
    cmd_ecall_ex = 1'b0;
    repeat (4) tick();
    chk("nested_back_handler", outs(), 8'h1B);
    stall = 1'b1; cmd_mret_ex = 1'b1;
    tick();
    chk("stalled_mret", {6'd0, dbg_state}, {6'd0, ST_HANDLER});
    stall = 1'b0;
    tick();
    cmd_mret_ex = 1'b0;
    chk("mret_idle", {6'd0, dbg_state}, {6'd0, ST_IDLE});

    // interrupt coinciding with exception: interrupt wins
    interrupt_tmr = 1'b1; illegal_ops_ex = 1'b1;
    tick();
    chk("irq_over_exc", outs(), 8'hA7);
    interrupt_tmr = 1'b0; illegal_ops_ex = 1'b0;
    repeat (4) tick();
    mret_to_idle();

    // pending under stall for 5 cycles, pulse one cycle after release
    interrupt_tmr = 1'b1; stall = 1'b1;
    repeat (5) tick();
    chk("stall_no_pulse", outs(), 8'h07);
    stall = 1'b0;
    tick();
    chk("stall_release_pulse", outs(), 8'hA7);
    interrupt_tmr = 1'b0;
    tick();                                // FLUSH, count 3
    stall = 1'b1;
    repeat (2) tick();
    chk("flush_frozen", {6'd0, dbg_state}, {6'd0, ST_FLUSH});
    stall = 1'b0;
    tick(); tick();                        // count 2, count 1
    chk("flush_last", outs(), 8'h27);
    tick();
    chk("flush_done_handler", outs(), 8'h17);
    mret_to_idle();

    // reset mid-flush (counter at 2): outputs clear immediately, no pulse later
    interrupt_tmr = 1'b1;
    tick();
    interrupt_tmr = 1'b0;
    tick(); tick();
    chk("pre_rst_flush", {6'd0, dbg_state}, {6'd0, ST_FLUSH});
    rst = 1'b1;
    #1;
    chk("rst_async_outs", outs(), 8'h00);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_release_idle", {6'd0, dbg_state}, {6'd0, ST_IDLE});
    tick();
    chk("rst_no_pulse", outs(), 8'h00);

    // external interrupt latency
    interrupt_ext = 1'b1;
    for (int i = 1; i < EXT_LAT; i++) begin
      tick();
      chk("ext_wait", {7'd0, g_interrupt}, 8'h00);
    end
    tick();
    chk("ext_pulse", outs(), 8'hAB);
    interrupt_ext = 1'b0;
    repeat (4) tick();
    mret_to_idle();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 3: number of pipeline-flush cycles after trap entry; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports interrupt_ext, interrupt_tmr and interrupt_sw, input, 1 bit each: level-sensitive MEI, MTI and MSI requests.
REQ-005 SHALL have ports csr_meie, csr_mtie and csr_msie, input, 1 bit each: per-source enables from the CSR block.
REQ-006 SHALL have port csr_mstatus_mie, input, 1 bit: global machine interrupt enable.
REQ-007 SHALL have ports illegal_ops_ex, cmd_ecall_ex and cmd_mret_ex, input, 1 bit each: EX-stage trap and return commands.
REQ-008 SHALL have port stall, input, 1 bit: pipeline stall; EX commands are ignored while it is high.
REQ-009 SHALL have port g_interrupt, output, 1 bit: one-cycle trap-entry pulse for an interrupt.
REQ-010 SHALL have port g_exception, output, 1 bit: one-cycle trap-entry pulse for an exception.
REQ-011 SHALL have port g_interrupt_priv, output, 2 bits: target privilege, fixed at 2'b11 (M-mode).
REQ-012 SHALL have port int_cause, output, 4 bits: latched cause code, 11 = MEI, 3 = MSI, 7 = MTI, 2 = illegal, 11 = ecall-M.
REQ-013 SHALL have port flush_req, output, 1 bit: flush request to IF/ID/EX.
REQ-014 SHALL have port in_handler, output, 1 bit: high while a trap handler runs; blocks further interrupts.

Function
REQ-015 SHALL define pending = (interrupt_ext&csr_meie) | (interrupt_sw&csr_msie) | (interrupt_tmr&csr_mtie), qualified by csr_mstatus_mie.
REQ-016 SHALL select a source with fixed priority MEI > MSI > MTI, evaluated in the sampling cycle only.
REQ-017 SHALL use a four-state FSM: IDLE, TRAP, FLUSH and HANDLER.
REQ-018 SHALL, in IDLE with pending and ~stall, latch the cause and go to TRAP; g_interrupt is high for exactly the TRAP cycle (1-cycle latency).
REQ-019 SHALL, in IDLE with (illegal_ops_ex|cmd_ecall_ex) and ~stall and no pending interrupt, latch the cause and go to TRAP with g_exception high instead of g_interrupt.
REQ-020 SHALL give an interrupt precedence when it coincides with an exception; the excepting instruction re-executes after mret.
REQ-021 SHALL decode illegal_ops_ex before cmd_ecall_ex when both are high.
REQ-022 SHALL assert flush_req during TRAP and FLUSH; FLUSH lasts FLUSH_CYCLES cycles via a 4-bit down-counter, then goes to HANDLER.
REQ-023 SHALL, in HANDLER, keep in_handler=1 and ignore interrupts.
REQ-024 SHALL, in HANDLER with cmd_mret_ex&~stall, go to IDLE; the earliest new interrupt pulse comes 2 cycles after the mret cycle.
REQ-025 SHALL, in HANDLER with an exception (~stall), pulse g_exception, update int_cause, re-enter FLUSH and return to HANDLER.
REQ-026 SHALL ignore cmd_mret_ex in IDLE, TRAP and FLUSH.
REQ-027 SHALL ignore source deassertion after sampling; the trap proceeds.
REQ-028 SHALL make stall freeze the FLUSH counter and delay the IDLE/HANDLER transitions.

Reset
REQ-029 SHALL, on rst, go to IDLE with g_interrupt=0, g_exception=0, flush_req=0, in_handler=0, int_cause=0 and counter=0; g_interrupt_priv=2'b11 at all times.
REQ-030 SHALL, when rst asserts mid-trap, abort immediately with no residual pulse after release.

Configuration
REQ-031 SHALL, with INTC_EXT_SYNC_EN defined, pass interrupt_ext through a two-flop synchronizer (reset 0), adding 2 cycles latency; without it, interrupt_ext is used directly.

Structure
REQ-032 SHALL place the state encoding, cause codes (2, 3, 7, 11) and M-mode constant 2'b11 in a shared package, cpu_trap_pkg.
REQ-033 SHALL implement the synchronizer as sub-module intc_sync2; everything else is in one module.

Verification
REQ-034 SHALL check: interrupt_tmr=1, csr_mtie=1, csr_mstatus_mie=1 -> g_interrupt pulse at cycle+1, int_cause=7, flush_req high 4 cycles, then in_handler=1.
REQ-035 SHALL check: all three sources plus enables in one cycle -> int_cause=11; after mret, with ext cleared, the next pulse gives int_cause=3.
REQ-036 SHALL check: illegal_ops_ex and cmd_ecall_ex together in IDLE -> g_exception pulse, int_cause=2, g_interrupt stays 0.
REQ-037 SHALL check: pending with stall=1 for 5 cycles -> no pulse; pulse 1 cycle after stall falls.
REQ-038 SHALL check: rst asserted in FLUSH with counter=2 -> all outputs 0 same cycle, IDLE after release, no pulse.
REQ-039 SHALL check: with INTC_EXT_SYNC_EN, interrupt_ext rise -> g_interrupt 3 cycles later (1 cycle without it).
